// File: rtl/a2d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : a2d_pkg
// Description : Shared types and constants for the A2D round-robin scheduler.
//               FSM state encoding, channel index type, default ADC128S
//               channel codes and the SPI command-word layout.
// Revision    : 1.0 - initial release
// ============================================================================
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WT_CMD = 3'd2,
    GAP    = 3'd3,
    RD     = 3'd4,
    WT_RD  = 3'd5
  } a2d_state_e;

  typedef logic [1:0] ch_idx_t;

  localparam int NUM_CH     = 4;
  localparam int RES_W      = 12;
  localparam int CMD_W      = 16;
  localparam int CMD_CH_LSB = 11;

  localparam logic [2:0] CH_LFT_DEF   = 3'd0;
  localparam logic [2:0] CH_RGHT_DEF  = 3'd4;
  localparam logic [2:0] CH_STEER_DEF = 3'd5;
  localparam logic [2:0] CH_BATT_DEF  = 3'd6;

  // Command word: two zero bits, 3-bit channel, 11 don't-care bits sent as 0.
  function automatic logic [CMD_W-1:0] a2d_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/a2d_ch_reg.sv
`default_nettype none
// ============================================================================
// Module      : a2d_ch_reg
// Description : One 12-bit channel result register.
//               With A2D_AVG_EN defined the register low-pass filters the
//               samples as new = (3*old + sample) >> 2, loading the raw
//               sample on the first update after reset (tracked by a primed
//               bit). Without it the raw sample is loaded.
// Ports       : clk, rst_n (async active-low), ld_en (load strobe),
//               sample[11:0] (new conversion), result[11:0] (held value)
// Macro       : A2D_AVG_EN
// Revision    : 1.0 - initial release
// ============================================================================
module a2d_ch_reg
  import a2d_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic [RES_W-1:0] sample,
  output logic [RES_W-1:0] result
);

  logic [RES_W-1:0] res_q, res_d;

`ifdef A2D_AVG_EN
  logic             primed_q, primed_d;
  logic [RES_W+1:0] acc;

  always_comb begin
    // 3*old + sample fits in 14 bits (max 16380); the >>2 keeps bits [13:2].
    acc      = {2'b00, res_q} + {1'b0, res_q, 1'b0} + {2'b00, sample};
    res_d    = res_q;
    primed_d = primed_q;
    if (ld_en) begin
      res_d    = primed_q ? acc[RES_W+1:2] : sample;
      primed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      res_q    <= res_d;
      primed_q <= primed_d;
    end
  end
`else
  always_comb begin
    res_d = ld_en ? sample : res_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end
`endif

  assign result = res_q;

endmodule
`default_nettype wire

// File: rtl/a2d_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : a2d_rr_sched
// Description : Round-robin conversion scheduler for the shared A2D SPI path.
//               On nxt it runs one round over left load cell, right load
//               cell, steer pot and battery. Each channel uses two SPI
//               transactions (command, then read with the same command);
//               the read's low 12 bits are the conversion.
// Ports       : clk, rst_n (async active-low)
//               nxt            - pulse, start one round
//               spi_wrt/spi_cmd - transaction start and command word
//               spi_done/spi_rd - transaction complete and returned word
//               lft_ld, rght_ld, steer_pot, batt - latest 12-bit results
//               busy           - round in progress
//               vld            - pulse, all four results are fresh
// Macro       : A2D_AVG_EN (enables averaging in a2d_ch_reg)
// Revision    : 1.0 - initial release
// ============================================================================
module a2d_rr_sched
  import a2d_pkg::*;
#(
  parameter logic [2:0] CH_LFT   = CH_LFT_DEF,
  parameter logic [2:0] CH_RGHT  = CH_RGHT_DEF,
  parameter logic [2:0] CH_STEER = CH_STEER_DEF,
  parameter logic [2:0] CH_BATT  = CH_BATT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nxt,
  output logic             spi_wrt,
  output logic [CMD_W-1:0] spi_cmd,
  input  logic             spi_done,
  input  logic [CMD_W-1:0] spi_rd,
  output logic [RES_W-1:0] lft_ld,
  output logic [RES_W-1:0] rght_ld,
  output logic [RES_W-1:0] steer_pot,
  output logic [RES_W-1:0] batt,
  output logic             busy,
  output logic             vld
);

  a2d_state_e       state_q, state_d;
  ch_idx_t          idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             vld_q, vld_d;
  logic             rd_done;
  logic [2:0]       ch_code;
  logic [RES_W-1:0] ch_res [NUM_CH];

  // Upper nibble of the returned word carries no conversion data.
  logic unused_rd_hi;
  assign unused_rd_hi = ^spi_rd[CMD_W-1:RES_W];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state logic. spi_done outside the two wait states falls through the
  // case untouched, which is how stray completions are ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (nxt) begin
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = CMD;
        end
      end
      CMD:    state_d = WT_CMD;
      WT_CMD: if (spi_done) state_d = GAP;
      GAP:    state_d = RD;
      RD:     state_d = WT_RD;
      WT_RD: begin
        if (spi_done) begin
          if (idx_q == ch_idx_t'(NUM_CH - 1)) begin
            vld_d   = 1'b1;
            busy_d  = 1'b0;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = CMD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The command is a pure function of the index, so it holds
  // steady for the whole transaction without a separate register.
  always_comb begin
    spi_wrt = (state_q == CMD) || (state_q == RD);
    rd_done = (state_q == WT_RD) && spi_done;
    case (idx_q)
      2'd0:    ch_code = CH_LFT;
      2'd1:    ch_code = CH_RGHT;
      2'd2:    ch_code = CH_STEER;
      default: ch_code = CH_BATT;
    endcase
  end

  assign spi_cmd = a2d_cmd(ch_code);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      a2d_ch_reg u_ch_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_en  (rd_done && (idx_q == ch_idx_t'(i))),
        .sample (spi_rd[RES_W-1:0]),
        .result (ch_res[i])
      );
    end
  endgenerate

  assign lft_ld    = ch_res[0];
  assign rght_ld   = ch_res[1];
  assign steer_pot = ch_res[2];
  assign batt      = ch_res[3];
  assign busy      = busy_q;
  assign vld       = vld_q;

endmodule
`default_nettype wire

// File: tb/tb_a2d_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_a2d_rr_sched
// Description : Self-checking bench for a2d_rr_sched with a behavioural
//               ADC128S-style SPI responder (a read returns the channel
//               addressed by the previous transaction, random upper nibble).
// Macro       : A2D_AVG_EN (switches the reference model to averaging)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_a2d_rr_sched;

`ifdef A2D_AVG_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif
  localparam int SPI_LAT   = 12;
  localparam int ROUND_LAT = 8 * SPI_LAT + 4 + 8 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd = 16'h0000;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        busy, vld;

  a2d_rr_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nxt       (nxt),
    .spi_wrt   (spi_wrt),
    .spi_cmd   (spi_cmd),
    .spi_done  (spi_done),
    .spi_rd    (spi_rd),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .busy      (busy),
    .vld       (vld)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] l;
    logic [11:0] r;
    logic [11:0] s;
    logic [11:0] b;
  } res_t;

  int compared = 0;
  int mismatched = 0;

  logic [11:0] ana [0:7];
  logic [11:0] mdl [0:3];
  bit          mdl_primed [0:3];
  logic [2:0]  codes [0:3];
  logic [15:0] exp_cmd_q [$];
  res_t        exp_res_q [$];

  int          wrt_cnt = 0;
  int          vld_cnt = 0;
  bit          outstanding = 1'b0;
  bit          stale = 1'b0;
  int          lat_cnt = 0;
  logic [15:0] cur_cmd = 16'h0000;
  logic [2:0]  prev_ch = 3'd0;

  function automatic logic [11:0] upd(input logic [11:0] old, input bit primed,
                                      input logic [11:0] s);
    int t;
    if (AVG_EN && primed) begin
      t = (int'(old) * 3 + int'(s)) / 4;
      return t[11:0];
    end
    return s;
  endfunction

  // SPI responder plus monitor/scoreboard, all evaluated on the falling edge.
  always @(negedge clk) begin
    if (!rst_n && outstanding) stale = 1'b1;
    if (spi_done) begin
      spi_done    = 1'b0;
      outstanding = 1'b0;
      stale       = 1'b0;
    end else if (outstanding) begin
      if (!stale) begin
        compared++;
        if (spi_cmd !== cur_cmd) begin
          mismatched++;
          $display("FAIL cmd_stable: spi_cmd=%h required %h", spi_cmd, cur_cmd);
        end
      end
      lat_cnt--;
      if (lat_cnt == 0) begin
        spi_done = 1'b1;
        spi_rd   = {4'($urandom), ana[prev_ch]};
        prev_ch  = cur_cmd[13:11];
      end
    end
    if (spi_wrt === 1'b1) begin
      wrt_cnt++;
      compared++;
      if (outstanding) begin
        mismatched++;
        $display("FAIL wrt_overlap: spi_wrt=1 required 0 while transaction outstanding");
      end
      compared++;
      if (exp_cmd_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_wrt: spi_cmd=%h with no transaction expected", spi_cmd);
      end else begin
        cur_cmd = exp_cmd_q.pop_front();
        if (spi_cmd !== cur_cmd) begin
          mismatched++;
          $display("FAIL cmd_seq: spi_cmd=%h required %h", spi_cmd, cur_cmd);
        end
      end
      outstanding = 1'b1;
      stale       = 1'b0;
      cur_cmd     = spi_cmd;
      lat_cnt     = SPI_LAT;
    end
    if (vld === 1'b1) begin
      res_t e;
      vld_cnt++;
      compared++;
      if (exp_res_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_vld: vld=1 with no round expected");
      end else begin
        e = exp_res_q.pop_front();
        if ({lft_ld, rght_ld, steer_pot, batt} !== e) begin
          mismatched++;
          $display("FAIL round_result: got %h/%h/%h/%h required %h/%h/%h/%h",
                   lft_ld, rght_ld, steer_pot, batt, e.l, e.r, e.s, e.b);
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      mdl[i]        = 12'h000;
      mdl_primed[i] = 1'b0;
    end
    exp_cmd_q.delete();
    exp_res_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    nxt   = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulses nxt for one cycle; when accepted, queues the expected commands
  // and the expected end-of-round results.
  task automatic pulse_nxt(input bit accept);
    @(negedge clk);
    nxt = 1'b1;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        mdl[i]        = upd(mdl[i], mdl_primed[i], ana[codes[i]]);
        mdl_primed[i] = 1'b1;
        exp_cmd_q.push_back({2'b00, codes[i], 11'h000});
        exp_cmd_q.push_back({2'b00, codes[i], 11'h000});
      end
      exp_res_q.push_back(res_t'({mdl[0], mdl[1], mdl[2], mdl[3]}));
    end
    @(negedge clk);
    nxt = 1'b0;
  endtask

  // Returns the falling-edge index (first edge after nxt is sampled = 1) at
  // which vld is seen; a timeout is reported as a failure.
  task automatic wait_vld(input string name, output int n);
    n = 1;
    while (vld !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (vld !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: vld=0 required 1 within 3000 cycles", name);
    end
  endtask

  task automatic run_round(input string name);
    int n;
    pulse_nxt(1'b1);
    wait_vld(name, n);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    if ({spi_wrt, spi_cmd, lft_ld, rght_ld, steer_pot, batt, busy, vld} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: wrt=%b cmd=%h l=%h r=%h s=%h b=%h busy=%b vld=%b required all 0",
               spi_wrt, spi_cmd, lft_ld, rght_ld, steer_pot, batt, busy, vld);
    end
    rst_n = 1'b1;
    begin
      int w0 = wrt_cnt;
      repeat (1000) @(negedge clk);
      compared++;
      if (wrt_cnt != w0 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL idle_quiet: wrt pulses=%0d busy=%b required 0 and 0", wrt_cnt - w0, busy);
      end
    end
  endtask

  task automatic test_full_round();
    int w0, n;
    ana[0] = 12'd330; ana[4] = 12'd320; ana[5] = 12'h800; ana[6] = 12'hFFF;
    w0 = wrt_cnt;
    pulse_nxt(1'b1);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_set: busy=%b required 1", busy);
    end
    wait_vld("full_round", n);
    compared++;
    if (n != ROUND_LAT) begin
      mismatched++;
      $display("FAIL latency: vld after %0d cycles required %0d", n, ROUND_LAT);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_clear: busy=%b required 0 with vld", busy);
    end
    @(negedge clk);
    compared++;
    if (wrt_cnt - w0 != 8) begin
      mismatched++;
      $display("FAIL wrt_count: %0d pulses required 8", wrt_cnt - w0);
    end
    compared++;
    if ({lft_ld, rght_ld, steer_pot, batt} !== {12'd330, 12'd320, 12'h800, 12'hFFF}) begin
      mismatched++;
      $display("FAIL full_values: got %h/%h/%h/%h required 14a/140/800/fff",
               lft_ld, rght_ld, steer_pot, batt);
    end
  endtask

  task automatic test_nxt_while_busy();
    int w0, v0, n;
    w0 = wrt_cnt;
    v0 = vld_cnt;
    pulse_nxt(1'b1);
    repeat (8) @(negedge clk);
    pulse_nxt(1'b0);
    wait_vld("busy_ignore", n);
    repeat (300) @(negedge clk);
    compared++;
    if (wrt_cnt - w0 != 8 || vld_cnt - v0 != 1) begin
      mismatched++;
      $display("FAIL nxt_while_busy: wrt=%0d vld=%0d required 8 and 1", wrt_cnt - w0, vld_cnt - v0);
    end
  endtask

  task automatic test_nxt_on_final_done();
    int w0, v0;
    w0 = wrt_cnt;
    v0 = vld_cnt;
    pulse_nxt(1'b1);
    // Land the second nxt in the cycle where the final spi_done is sampled.
    repeat (ROUND_LAT - 3) @(negedge clk);
    pulse_nxt(1'b0);
    repeat (300) @(negedge clk);
    compared++;
    if (wrt_cnt - w0 != 8 || vld_cnt - v0 != 1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL nxt_final_done: wrt=%0d vld=%0d busy=%b required 8, 1, 0",
               wrt_cnt - w0, vld_cnt - v0, busy);
    end
  endtask

  task automatic test_reset_mid_round();
    int w0, v0, n;
    w0 = wrt_cnt;
    pulse_nxt(1'b1);
    n = 0;
    while (wrt_cnt - w0 < 6 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    compared++;
    if ({spi_wrt, lft_ld, rght_ld, steer_pot, batt, busy, vld} !== '0) begin
      mismatched++;
      $display("FAIL mid_reset: wrt=%b l=%h r=%h s=%h b=%h busy=%b vld=%b required all 0",
               spi_wrt, lft_ld, rght_ld, steer_pot, batt, busy, vld);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w0 = wrt_cnt;
    v0 = vld_cnt;
    n = 0;
    while (outstanding && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || wrt_cnt != w0 || vld_cnt != v0 || steer_pot !== 12'h000) begin
      mismatched++;
      $display("FAIL late_done: busy=%b wrt=%0d vld=%0d steer=%h required 0, 0, 0, 000",
               busy, wrt_cnt - w0, vld_cnt - v0, steer_pot);
    end
    ana[5] = 12'h123;
    run_round("after_reset");
    compared++;
    if ({lft_ld, rght_ld, steer_pot, batt} !== {12'd330, 12'd320, 12'h123, 12'hFFF}) begin
      mismatched++;
      $display("FAIL clean_round: got %h/%h/%h/%h required 14a/140/123/fff",
               lft_ld, rght_ld, steer_pot, batt);
    end
  endtask

  task automatic test_steer_change();
    ana[5] = 12'hD00;
    run_round("steer_d00");
    compared++;
    if (steer_pot !== mdl[2] || lft_ld !== 12'd330 || rght_ld !== 12'd320) begin
      mismatched++;
      $display("FAIL steer_d00: s=%h l=%h r=%h required %h/14a/140", steer_pot, lft_ld, rght_ld, mdl[2]);
    end
    ana[5] = 12'h400;
    run_round("steer_400");
    compared++;
    if (steer_pot !== mdl[2] || lft_ld !== 12'd330 || rght_ld !== 12'd320) begin
      mismatched++;
      $display("FAIL steer_400: s=%h l=%h r=%h required %h/14a/140", steer_pot, lft_ld, rght_ld, mdl[2]);
    end
  endtask

  task automatic test_batt_avg();
    do_reset();
    ana[6] = 12'h400;
    run_round("batt_400");
    compared++;
    if (batt !== 12'h400) begin
      mismatched++;
      $display("FAIL batt_first: batt=%h required 400", batt);
    end
    ana[6] = 12'h800;
    run_round("batt_800");
    compared++;
    if (batt !== (AVG_EN ? 12'h500 : 12'h800)) begin
      mismatched++;
      $display("FAIL batt_second: batt=%h required %h", batt, AVG_EN ? 12'h500 : 12'h800);
    end
  endtask

  initial begin
    codes[0] = 3'd0; codes[1] = 3'd4; codes[2] = 3'd5; codes[3] = 3'd6;
    for (int i = 0; i < 8; i++) ana[i] = 12'h000;
    clear_model();
    test_reset();
    test_full_round();
    test_nxt_while_busy();
    test_nxt_on_final_done();
    test_reset_mid_round();
    test_steer_change();
    test_batt_avg();
    compared++;
    if (exp_cmd_q.size() != 0 || exp_res_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: %0d commands and %0d results never seen, required 0 and 0",
               exp_cmd_q.size(), exp_res_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
